reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 4, number of sequenced reset outputs (2..16).
REQ-002 SHALL have parameter SYNC_DEPTH, default 3, synchronizer chain length (>=2).
REQ-003 SHALL have parameter PULSE_MIN, default 16, cycles all outputs stay asserted in HOLD (>=1).
REQ-004 SHALL have parameter GAP_CYCLES, default 8, cycles between successive domain releases (>=1).
REQ-005 SHALL have port clock  input  1  sole clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port io_sw_req  input  1  asynchronous warm-reset request; a rising edge triggers a sequence.
REQ-008 SHALL have port io_rst_out  output  N_DOMAINS  active-high domain resets; bit i releases before bit i+1.
REQ-009 SHALL have port io_busy  output  1  high whenever the FSM is not in RUN.
REQ-010 SHALL have port io_done  output  1  high only in RUN.

Function
REQ-011 SHALL implement FSM states ASSERT, HOLD, RELEASE, RUN.
REQ-012 ASSERT: all io_rst_out high; exits to HOLD on the first edge the internal reset-sync chain output is sampled high.
REQ-013 The reset-sync chain SHALL have input tied to 1 and be cleared by reset, so its output goes high after edge SYNC_DEPTH following reset deassertion.
REQ-014 HOLD: all outputs high; counter runs PULSE_MIN cycles; the FSM enters HOLD at edge h, and io_rst_out[0] SHALL fall at edge h+PULSE_MIN, entering RELEASE.
REQ-015 RELEASE: io_rst_out[i] SHALL fall at edge h+PULSE_MIN+i*GAP_CYCLES; once released, a bit stays low until the next sequence.
REQ-016 The FSM SHALL enter RUN on the same edge the last bit falls; io_done rises on that edge.
REQ-017 io_sw_req SHALL pass through a second SYNC_DEPTH chain; a 0->1 transition of its output SHALL be detected against a registered copy of that output.
REQ-018 In RUN, a detected edge SHALL drive all io_rst_out high and enter HOLD on edge e+SYNC_DEPTH, where e is the first edge sampling io_sw_req=1.
REQ-019 Edges detected outside RUN SHALL be ignored and not queued; a request held high across a sequence SHALL NOT retrigger.
REQ-020 Counter width SHALL be clog2(max(PULSE_MIN,GAP_CYCLES)+1); the domain index width SHALL be clog2(N_DOMAINS); neither SHALL wrap within a sequence.
REQ-021 All outputs SHALL be registered; io_rst_out SHALL have no combinational path from any input.

Reset
REQ-022 Reset assertion SHALL immediately and asynchronously drive io_rst_out all ones, io_busy=1, io_done=0, FSM=ASSERT, clear both chains, the edge register and the counters.
REQ-023 Reset asserted mid-sequence or in RUN SHALL abort to ASSERT, and the full power-on sequence SHALL restart after deassertion.
REQ-024 No register SHALL use synchronous reset.

Structure
REQ-025 A shared package SHALL hold the FSM state enum and the default parameter constants.
REQ-026 Sub-module reset_sync_chain (parameter DEPTH; ports clock, reset, io_d, io_q; async-clear shift register, reset value 0) SHALL be instantiated twice.
REQ-027 Total RTL SHALL be 120-400 lines.

Verification (defaults; edge n = nth rising edge after reset deassertion)
REQ-028 Power-on: reset released before edge 1 -> io_rst_out=4'hF through edge 19; bit0 falls at edge 20, bit1 at 28, bit2 at 36, bit3 at 44; io_done=1 from edge 44.
REQ-029 Warm reset: in RUN, io_sw_req rises before edge e=100 and stays high -> io_rst_out=4'hF at edge 103; bit0 falls at 119, bit3 at 143; no second sequence follows.
REQ-030 Request while busy: io_sw_req pulsed for 4 cycles at edge 30 -> the sequence is unchanged and io_done=1 at edge 44 with no retrigger.
REQ-031 Mid-sequence reset: reset asserted asynchronously at edge 30 +2ns -> io_rst_out=4'hF within the same cycle; after release, the timing of REQ-028 repeats.
REQ-032 Parameter sweep: N_DOMAINS=2, GAP_CYCLES=1, PULSE_MIN=1 -> bit0 falls at edge 5, bit1 at edge 6, io_done at edge 6.
REQ-033 Assertion check: a low bit i never coexists with a high bit j<i, except for all-ones re-assertion.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg
// Purpose : shared definitions for the reset sequencer slice.
//           - default parameter constants
//           - the sequencer FSM state enum
//           - a small max helper used when sizing counters
// Ports   : none (package)
package reset_sequencer_pkg;

  localparam int DEF_N_DOMAINS  = 4;
  localparam int DEF_SYNC_DEPTH = 3;
  localparam int DEF_PULSE_MIN  = 16;
  localparam int DEF_GAP_CYCLES = 8;

  // ASSERT waits for the power-on sync chain.
  // HOLD keeps every domain in reset for the minimum pulse.
  // RELEASE frees one domain per gap interval.
  // RUN is the steady state.
  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } seqState_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Purpose : bundles the sequencer's request/status signals.
// Signals : io_sw_req  - asynchronous warm-reset request (into the sequencer)
//           io_rst_out - active-high per-domain resets (bit 0 releases first)
//           io_busy    - high while a sequence is in progress
//           io_done    - high only once every domain has been released
// Modports: master - the sequencer side
//           slave  - the consumer / requester side
interface reset_sequencer_if
  import reset_sequencer_pkg::*;
#(
  parameter int N_DOMAINS = DEF_N_DOMAINS
) ();

  logic                 io_sw_req;
  logic [N_DOMAINS-1:0] io_rst_out;
  logic                 io_busy;
  logic                 io_done;

  modport master (
    input  io_sw_req,
    output io_rst_out,
    output io_busy,
    output io_done
  );

  modport slave (
    output io_sw_req,
    input  io_rst_out,
    input  io_busy,
    input  io_done
  );

endinterface

// File: rtl/reset_sequencer_sync_chain.sv
// reset_sync_chain
// Purpose : DEPTH-stage shift register used both as a reset-release
//           synchronizer (input tied high) and as a metastability
//           synchronizer for the asynchronous warm-reset request.
// Ports   : clock - sole clock
//           reset - asynchronous active-high clear (all stages to 0)
//           io_d  - data input (may be asynchronous to clock)
//           io_q  - synchronized output, last stage of the chain
module reset_sync_chain #(
  parameter int DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic io_d,
  output logic io_q
);

  logic [DEPTH-1:0] chain_q;

  // Shift io_d in at the low end; reset clears every stage so the output
  // only rises DEPTH edges after a high input is first sampled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[DEPTH-2:0], io_d};
    end
  end

  assign io_q = chain_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Purpose : sequences N_DOMAINS active-high resets. After power-on reset
//           or a warm-reset request it holds all domains in reset for
//           PULSE_MIN cycles, then releases domain 0, 1, ... one every
//           GAP_CYCLES cycles, and finally reports done.
// Ports   : clock - sole clock
//           reset - asynchronous active-high reset
//           bus   - reset_sequencer_if.master
//                   (io_sw_req in; io_rst_out, io_busy, io_done out)
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_DOMAINS  = DEF_N_DOMAINS,
  parameter int SYNC_DEPTH = DEF_SYNC_DEPTH,
  parameter int PULSE_MIN  = DEF_PULSE_MIN,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  reset_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(maxInt(PULSE_MIN, GAP_CYCLES) + 1);
  localparam int IDX_W = $clog2(N_DOMAINS);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PULSE_MIN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic                 porSync;
  logic                 swSync;
  logic                 swPrev_q;
  logic                 swRise;
  seqState_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [N_DOMAINS-1:0] rstOut_q;
  logic                 busy_q;
  logic                 done_q;

  // Power-on chain: input tied high, so its output marks the point where
  // reset deassertion has been safely synchronized into the clock domain.
  reset_sync_chain #(.DEPTH(SYNC_DEPTH)) uPorSync (
    .clock (clock),
    .reset (reset),
    .io_d  (1'b1),
    .io_q  (porSync)
  );

  // Warm-request chain: brings the asynchronous request into the domain.
  reset_sync_chain #(.DEPTH(SYNC_DEPTH)) uSwSync (
    .clock (clock),
    .reset (reset),
    .io_d  (bus.io_sw_req),
    .io_q  (swSync)
  );

  // A request counts once per 0->1 transition, so a held request cannot
  // retrigger after the sequence it started has finished.
  assign swRise = swSync & ~swPrev_q;

  // Sequencer FSM. All outputs are registered here so io_rst_out has no
  // combinational path from any input. cnt_q counts cycles within HOLD
  // and within each RELEASE gap; idx_q names the next domain to free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ASSERT;
      cnt_q    <= '0;
      idx_q    <= '0;
      rstOut_q <= '1;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      swPrev_q <= 1'b0;
    end else begin
      swPrev_q <= swSync;
      case (state_q)
        ST_ASSERT: begin
          rstOut_q <= '1;
          if (porSync) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rstOut_q[0] <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= IDX_ONE;
            state_q     <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            rstOut_q[idx_q] <= 1'b0;
            cnt_q           <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          // Warm reset skips ASSERT: the request chain already provided
          // the synchronization delay.
          if (swRise) begin
            rstOut_q <= '1;
            cnt_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            state_q  <= ST_HOLD;
          end
        end
        default: begin
          state_q <= ST_ASSERT;
        end
      endcase
    end
  end

  assign bus.io_rst_out = rstOut_q;
  assign bus.io_busy    = busy_q;
  assign bus.io_done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Purpose : self-checking bench for reset_sequencer. Two instances share
//           clock, reset and the warm request: one with default
//           parameters and one with N_DOMAINS=2, PULSE_MIN=1,
//           GAP_CYCLES=1. Expected outputs come from release-edge
//           arithmetic: a sequence that enters HOLD at edge h frees bit i
//           after edge h+PULSE_MIN+i*GAP_CYCLES.
// Ports   : none (top-level bench)
module tb_reset_sequencer;

  localparam int SYNC = 3;
  localparam int NA = 4;
  localparam int PA = 16;
  localparam int GA = 8;
  localparam int NB = 2;
  localparam int PB = 1;
  localparam int GB = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic swReq = 1'b0;

  int checks = 0;
  int errors = 0;

  int edgeCnt = 0;
  bit inReset = 1'b1;
  bit reqPrev = 1'b0;
  int hStart [2];
  int pending [$];

  reset_sequencer_if #(.N_DOMAINS(NA)) busA ();
  reset_sequencer_if #(.N_DOMAINS(NB)) busB ();

  assign busA.io_sw_req = swReq;
  assign busB.io_sw_req = swReq;

  reset_sequencer #(
    .N_DOMAINS  (NA),
    .SYNC_DEPTH (SYNC),
    .PULSE_MIN  (PA),
    .GAP_CYCLES (GA)
  ) dutA (
    .clock (clock),
    .reset (reset),
    .bus   (busA)
  );

  reset_sequencer #(
    .N_DOMAINS  (NB),
    .SYNC_DEPTH (SYNC),
    .PULSE_MIN  (PB),
    .GAP_CYCLES (GB)
  ) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (busB)
  );

  always #5 clock = ~clock;

  function automatic int domCount(input int d);
    return (d == 0) ? NA : NB;
  endfunction

  function automatic int pulseLen(input int d);
    return (d == 0) ? PA : PB;
  endfunction

  function automatic int gapLen(input int d);
    return (d == 0) ? GA : GB;
  endfunction

  // Edge after which the last domain of the current sequence is free.
  function automatic int doneEdge(input int d);
    return hStart[d] + pulseLen(d) + (domCount(d) - 1) * gapLen(d);
  endfunction

  function automatic logic [15:0] expRst(input int d);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < domCount(d); i++) begin
      v[i] = inReset ? 1'b1 : (edgeCnt < hStart[d] + pulseLen(d) + i * gapLen(d));
    end
    return v;
  endfunction

  function automatic logic expDone(input int d);
    return inReset ? 1'b0 : (edgeCnt >= doneEdge(d));
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edgeCnt, obs, exp);
    end
  endtask

  // Released bits must always form a contiguous low run starting at bit 0.
  function automatic logic orderOk(input logic [15:0] rst, input int n);
    logic [15:0] mask;
    logic [15:0] inv;
    mask = 16'((32'd1 << n) - 1);
    inv  = ~rst & mask;
    return ((inv & (inv + 16'd1)) == 16'd0);
  endfunction

  task automatic checkAll();
    logic [15:0] rstA;
    logic [15:0] rstB;
    rstA = {12'd0, busA.io_rst_out};
    rstB = {14'd0, busB.io_rst_out};
    checkOutput("rstA",   rstA, expRst(0));
    checkOutput("busyA",  {15'd0, busA.io_busy}, {15'd0, ~expDone(0)});
    checkOutput("doneA",  {15'd0, busA.io_done}, {15'd0, expDone(0)});
    checkOutput("orderA", {15'd0, orderOk(rstA, NA)}, 16'd1);
    checkOutput("rstB",   rstB, expRst(1));
    checkOutput("busyB",  {15'd0, busB.io_busy}, {15'd0, ~expDone(1)});
    checkOutput("doneB",  {15'd0, busB.io_done}, {15'd0, expDone(1)});
    checkOutput("orderB", {15'd0, orderOk(rstB, NB)}, 16'd1);
  endtask

  // Reference update at a counted edge: a request rise sampled at edge e
  // becomes a warm reset at edge e+SYNC, taken only by an instance that
  // was already done before that edge.
  task automatic modelEdge();
    if (swReq && !reqPrev) begin
      pending.push_back(edgeCnt + SYNC);
    end
    reqPrev = swReq;
    while (pending.size() > 0 && pending[0] == edgeCnt) begin
      for (int d = 0; d < 2; d++) begin
        if (edgeCnt - 1 >= doneEdge(d)) begin
          hStart[d] = edgeCnt;
        end
      end
      void'(pending.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!inReset) begin
      edgeCnt++;
      modelEdge();
    end
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic req, input int cycles);
    swReq = req;
    repeat (cycles) tick();
  endtask

  // Called 1ns after an edge; asserts reset 2ns after the edge and checks
  // the asynchronous response before the next edge.
  task automatic assertReset();
    #1;
    reset   = 1'b1;
    inReset = 1'b1;
    pending.delete();
    reqPrev = 1'b0;
    #1;
    checkAll();
  endtask

  task automatic releaseReset();
    #3;
    reset     = 1'b0;
    inReset   = 1'b0;
    edgeCnt   = 0;
    hStart[0] = SYNC + 1;
    hStart[1] = SYNC + 1;
  endtask

  // Directed sequence with randomized timing; every clock is checked.
  initial begin
    int gapLow;
    int holdHigh;
    int midWait;
    hStart[0] = SYNC + 1;
    hStart[1] = SYNC + 1;

    applyStimulus(1'b0, 3);
    releaseReset();

    applyStimulus(1'b0, 29);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 30);

    gapLow   = int'($urandom_range(10, 40));
    holdHigh = int'($urandom_range(60, 80));
    applyStimulus(1'b0, gapLow);
    applyStimulus(1'b1, holdHigh);
    applyStimulus(1'b0, 20);

    applyStimulus(1'b1, int'($urandom_range(4, 8)));
    applyStimulus(1'b0, 50);

    midWait = int'($urandom_range(0, 30));
    applyStimulus(1'b1, 6);
    applyStimulus(1'b0, midWait);
    assertReset();
    applyStimulus(1'b0, int'($urandom_range(1, 3)));
    releaseReset();

    applyStimulus(1'b0, 30);
    assertReset();
    applyStimulus(1'b0, 2);
    releaseReset();
    applyStimulus(1'b0, 50);

    assertReset();
    applyStimulus(1'b1, 2);
    releaseReset();
    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 10);

    applyStimulus(1'b1, int'($urandom_range(4, 10)));
    applyStimulus(1'b0, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
